// File: rtl/regfile_write_arbiter_pkg.sv
// Shared defaults and encodings for the register-file write-port arbiter.
// Imported by the interface, the round-robin arbiter and the top level.
package regfile_write_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NREGS_DEF  = 32;

  typedef enum logic {
    StClear = 1'b0,
    StRun   = 1'b1
  } state_e;

  typedef enum logic {
    PtrA = 1'b0,
    PtrB = 1'b1
  } rr_ptr_e;

  // Opposite side of the round-robin pointer.
  function automatic rr_ptr_e rr_other(input rr_ptr_e ptr);
    return (ptr == PtrA) ? PtrB : PtrA;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request handshakes (ports A and B) plus the register-file write port.
// The arbiter uses the slave modport; the datapath/regfile side uses master.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  logic              req_valid_a;
  logic [ADDR_W-1:0] req_addr_a;
  logic [DATA_W-1:0] req_data_a;
  logic              req_ready_a;

  logic              req_valid_b;
  logic [ADDR_W-1:0] req_addr_b;
  logic [DATA_W-1:0] req_data_b;
  logic              req_ready_b;

  logic [ADDR_W-1:0] write_register;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;

  modport slave (
    input  req_valid_a, req_addr_a, req_data_a,
    output req_ready_a,
    input  req_valid_b, req_addr_b, req_data_b,
    output req_ready_b,
    output write_register, write_data, reg_write
  );

  modport master (
    output req_valid_a, req_addr_a, req_data_a,
    input  req_ready_a,
    output req_valid_b, req_addr_b, req_data_b,
    input  req_ready_b,
    input  write_register, write_data, reg_write
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant. The pointer names the side that wins the next
// conflict and only advances when both sides request while enabled.
module regfile_write_arbiter_rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_valid_a,
  input  logic i_valid_b,
  output logic o_grant_a,
  output logic o_grant_b
);

  rr_ptr_e r_ptr;
  logic    w_conflict;

  assign w_conflict = i_en & i_valid_a & i_valid_b;

  assign o_grant_a = i_en & i_valid_a & (~i_valid_b | (r_ptr == PtrA));
  assign o_grant_b = i_en & i_valid_b & (~i_valid_a | (r_ptr == PtrB));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= PtrA;
    end else if (w_conflict) begin
      r_ptr <= rr_other(r_ptr);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between two writeback requesters and
// zero-fills registers 1..NREGS-1 after reset or on ClearReq.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NREGS  = NREGS_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_clear_req,
  output logic                    o_clear_busy,
  regfile_write_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LastReg  = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] FirstReg = ADDR_W'(1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_wr_reg;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_reg_write;
  logic              r_clear_busy;

  logic              w_arb_en;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_accept;
  logic              w_do_write;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_data;

  // ClearReq blocks grants in its own cycle so nothing is lost across the fill.
  assign w_arb_en = (r_state == StRun) & ~i_clear_req;

  regfile_write_arbiter_rr_arbiter2 u_rr (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_en      (w_arb_en),
    .i_valid_a (bus.req_valid_a),
    .i_valid_b (bus.req_valid_b),
    .o_grant_a (w_grant_a),
    .o_grant_b (w_grant_b)
  );

  always_comb begin
    w_acc_addr = bus.req_addr_a;
    w_acc_data = bus.req_data_a;
    if (w_grant_b) begin
      w_acc_addr = bus.req_addr_b;
      w_acc_data = bus.req_data_b;
    end
  end

  assign w_accept   = w_grant_a | w_grant_b;
  // Writes to register 0 are accepted but dropped.
  assign w_do_write = w_accept & (w_acc_addr != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StClear;
      r_cnt        <= FirstReg;
      r_wr_reg     <= '0;
      r_wr_data    <= '0;
      r_reg_write  <= 1'b0;
      r_clear_busy <= 1'b1;
    end else begin
      case (r_state)
        StClear: begin
          r_reg_write  <= 1'b1;
          r_wr_reg     <= r_cnt;
          r_wr_data    <= '0;
          r_clear_busy <= 1'b1;
          if (r_cnt == LastReg) begin
            r_state <= StRun;
            r_cnt   <= FirstReg;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StRun: begin
          if (i_clear_req) begin
            r_state      <= StClear;
            r_cnt        <= FirstReg;
            r_reg_write  <= 1'b0;
            r_clear_busy <= 1'b1;
          end else begin
            r_clear_busy <= 1'b0;
            r_reg_write  <= w_do_write;
            if (w_do_write) begin
              r_wr_reg  <= w_acc_addr;
              r_wr_data <= w_acc_data;
            end
          end
        end
        default: begin
          r_state <= StClear;
          r_cnt   <= FirstReg;
        end
      endcase
    end
  end

  assign bus.req_ready_a    = w_grant_a;
  assign bus.req_ready_b    = w_grant_b;
  assign bus.write_register = r_wr_reg;
  assign bus.write_data     = r_wr_data;
  assign bus.reg_write      = r_reg_write;
  assign o_clear_busy       = r_clear_busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: zero-fill, arbitration vector table, ClearReq and reset-mid-fill.
// A behavioural register file captures the write port to check landed values.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic clear_req;
  logic clear_busy;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_clear_req  (clear_req),
    .o_clear_busy (clear_busy),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] rf [32];

  always @(posedge clk) begin
    if (bus.reg_write && bus.write_register != 5'd0) rf[bus.write_register] <= bus.write_data;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic va, input logic [4:0] aa, input logic [31:0] da,
                         input logic vb, input logic [4:0] ab, input logic [31:0] db);
    bus.req_valid_a = va;
    bus.req_addr_a  = aa;
    bus.req_data_a  = da;
    bus.req_valid_b = vb;
    bus.req_addr_b  = ab;
    bus.req_data_b  = db;
  endtask

  // Checks fill steps 1..n; ready stays low until the last fill write is on the outputs.
  task automatic run_fill(input int n);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("fill_rw[%0d]", i), bus.reg_write, 1);
      chk($sformatf("fill_wr[%0d]", i), bus.write_register, i);
      chk($sformatf("fill_wd[%0d]", i), bus.write_data, 0);
      chk($sformatf("fill_busy[%0d]", i), clear_busy, 1);
      if (i < 31) begin
        chk($sformatf("fill_rdy_a[%0d]", i), bus.req_ready_a, 0);
        chk($sformatf("fill_rdy_b[%0d]", i), bus.req_ready_b, 0);
      end
    end
  endtask

  typedef struct {
    logic        va;
    logic [4:0]  aa;
    logic [31:0] da;
    logic        vb;
    logic [4:0]  ab;
    logic [31:0] db;
    logic        rdy_a;
    logic        rdy_b;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    // va aa da vb ab db | rdy_a rdy_b rw wr wd
    vecs[0]  = '{1'b1, 5'd2,  32'd42,  1'b0, 5'd0,  32'd0,   1'b1, 1'b0, 1'b1, 5'd2,  32'd42};
    vecs[1]  = '{1'b0, 5'd0,  32'd0,   1'b0, 5'd0,  32'd0,   1'b0, 1'b0, 1'b0, 5'd2,  32'd42};
    vecs[2]  = '{1'b1, 5'd3,  32'd15,  1'b1, 5'd4,  32'd18,  1'b1, 1'b0, 1'b1, 5'd3,  32'd15};
    vecs[3]  = '{1'b1, 5'd3,  32'd15,  1'b1, 5'd4,  32'd18,  1'b0, 1'b1, 1'b1, 5'd4,  32'd18};
    vecs[4]  = '{1'b1, 5'd3,  32'd15,  1'b1, 5'd4,  32'd18,  1'b1, 1'b0, 1'b1, 5'd3,  32'd15};
    vecs[5]  = '{1'b1, 5'd3,  32'd15,  1'b1, 5'd4,  32'd18,  1'b0, 1'b1, 1'b1, 5'd4,  32'd18};
    vecs[6]  = '{1'b0, 5'd0,  32'd0,   1'b1, 5'd0,  32'd18,  1'b0, 1'b1, 1'b0, 5'd4,  32'd18};
    vecs[7]  = '{1'b0, 5'd0,  32'd0,   1'b1, 5'd5,  32'd7,   1'b0, 1'b1, 1'b1, 5'd5,  32'd7};
    vecs[8]  = '{1'b1, 5'd6,  32'd100, 1'b1, 5'd7,  32'd200, 1'b1, 1'b0, 1'b1, 5'd6,  32'd100};
    vecs[9]  = '{1'b1, 5'd8,  32'd1,   1'b0, 5'd0,  32'd0,   1'b1, 1'b0, 1'b1, 5'd8,  32'd1};
    vecs[10] = '{1'b1, 5'd9,  32'd9,   1'b1, 5'd10, 32'd10,  1'b0, 1'b1, 1'b1, 5'd10, 32'd10};
    vecs[11] = '{1'b1, 5'd29, 32'd15,  1'b0, 5'd0,  32'd0,   1'b1, 1'b0, 1'b1, 5'd29, 32'd15};

    for (int r = 0; r < 32; r++) rf[r] = (r == 0) ? 32'd0 : 32'hDEAD_BEEF;

    reset     = 1'b1;
    clear_req = 1'b0;
    set_req(1'b1, 5'd5, 32'd1, 1'b1, 5'd6, 32'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rw", bus.reg_write, 0);
    chk("rst_wr", bus.write_register, 0);
    chk("rst_wd", bus.write_data, 0);
    chk("rst_busy", clear_busy, 1);
    chk("rst_rdy_a", bus.req_ready_a, 0);
    chk("rst_rdy_b", bus.req_ready_b, 0);
    reset = 1'b0;

    // Post-reset fill with both requesters pending.
    run_fill(31);
    chk("first_run_rdy_a", bus.req_ready_a, 1);
    chk("first_run_rdy_b", bus.req_ready_b, 0);
    set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("post_fill_rw", bus.reg_write, 0);
    chk("post_fill_busy", clear_busy, 0);
    chk("rf1_zero", rf[1], 0);
    chk("rf7_zero", rf[7], 0);
    chk("rf31_zero", rf[31], 0);

    for (int v = 0; v < 12; v++) begin
      set_req(vecs[v].va, vecs[v].aa, vecs[v].da, vecs[v].vb, vecs[v].ab, vecs[v].db);
      #1;
      chk($sformatf("vec%0d_rdy_a", v), bus.req_ready_a, vecs[v].rdy_a);
      chk($sformatf("vec%0d_rdy_b", v), bus.req_ready_b, vecs[v].rdy_b);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_rw", v), bus.reg_write, vecs[v].rw);
      chk($sformatf("vec%0d_wr", v), bus.write_register, vecs[v].wr);
      chk($sformatf("vec%0d_wd", v), bus.write_data, vecs[v].wd);
    end

    // ClearReq right after the reg-29 write is on the outputs, with A pending.
    set_req(1'b1, 5'd11, 32'd55, 1'b0, 5'd0, 32'd0);
    clear_req = 1'b1;
    #1;
    chk("clr_no_grant_a", bus.req_ready_a, 0);
    @(posedge clk);
    @(negedge clk);
    clear_req = 1'b0;
    chk("clr_rw", bus.reg_write, 0);
    chk("clr_busy", clear_busy, 1);
    chk("rf2_42", rf[2], 42);
    chk("rf3_15", rf[3], 15);
    chk("rf4_18", rf[4], 18);
    chk("rf0_zero", rf[0], 0);
    chk("rf5_7", rf[5], 7);
    chk("rf6_100", rf[6], 100);
    chk("rf10_10", rf[10], 10);
    chk("rf29_15", rf[29], 15);
    run_fill(31);
    chk("clr_first_run_rdy_a", bus.req_ready_a, 1);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("clr_a_rw", bus.reg_write, 1);
    chk("clr_a_wr", bus.write_register, 11);
    chk("clr_a_wd", bus.write_data, 55);
    chk("rf29_cleared", rf[29], 0);
    chk("rf2_cleared", rf[2], 0);

    // Reset at fill step 10 restarts the full fill.
    set_req(1'b1, 5'd12, 32'd3, 1'b1, 5'd13, 32'd4);
    clear_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_req = 1'b0;
    run_fill(10);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rw", bus.reg_write, 0);
    chk("midrst_wr", bus.write_register, 0);
    chk("midrst_busy", clear_busy, 1);
    reset = 1'b0;
    run_fill(31);
    chk("midrst_run_rdy_a", bus.req_ready_a, 1);
    chk("midrst_run_rdy_b", bus.req_ready_b, 0);
    set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_end_rw", bus.reg_write, 0);
    chk("midrst_end_busy", clear_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
